// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential radix-2 divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_ITER  = DIV_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ZERO,
    CALC,
    DONE
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {r,q} left, trial-subtract |b| at WIDTH+1 bits.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [2*WIDTH-1:0] rq,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] rq_next
);

  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    r_sh = rq[2*WIDTH-1:WIDTH-1];
    diff = r_sh - {1'b0, b_mag};
    if (diff[WIDTH]) begin
      rq_next = {r_sh[WIDTH-1:0], rq[WIDTH-2:0], 1'b0};
    end else begin
      rq_next = {diff[WIDTH-1:0], rq[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU with start/annul/ready handshake.
// Optional DIV_EARLY_OUT_EN: finish early when |a| < |b| (same results, shorter latency).
module seq_div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  div_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [2*WIDTH-1:0]  rq_q, rq_step;
  logic [WIDTH-1:0]    bmag_q;
  logic [WIDTH-1:0]    a_mag, b_mag;
  logic                q_neg_q, r_neg_q;
  logic                early_q, early_d;
  logic                accept, last_iter;
  logic [WIDTH-1:0]    q_fix, r_fix, early_rem;
  logic [2*WIDTH-1:0]  result_q;
  logic                ready_q;

  assign accept    = start_i && !annul_i;
  assign last_iter = (cnt_q == CW'(WIDTH-1));
  assign a_mag     = (signed_div_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag     = (signed_div_i && b_i[WIDTH-1]) ? -b_i : b_i;

`ifdef DIV_EARLY_OUT_EN
  assign early_d = (b_i != '0) && (a_mag < b_mag);
`else
  assign early_d = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rq      (rq_q),
    .b_mag   (bmag_q),
    .rq_next (rq_step)
  );

  assign q_fix     = q_neg_q ? -rq_step[WIDTH-1:0]       : rq_step[WIDTH-1:0];
  assign r_fix     = r_neg_q ? -rq_step[2*WIDTH-1:WIDTH] : rq_step[2*WIDTH-1:WIDTH];
  assign early_rem = r_neg_q ? -rq_q[WIDTH-1:0]          : rq_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = ((b_i == '0) || early_d) ? ZERO : CALC;
      ZERO: state_d = annul_i ? IDLE : DONE;
      CALC: begin
        if (annul_i)        state_d = IDLE;
        else if (last_iter) state_d = DONE;
      end
      DONE: if (annul_i || !start_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Early-out reuses the ZERO state so ready_o still rises in the second cycle;
  // the latched dividend magnitude is sign-restored into the remainder there.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rq_q     <= '0;
      bmag_q   <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      early_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            rq_q    <= {{WIDTH{1'b0}}, a_mag};
            bmag_q  <= b_mag;
            q_neg_q <= signed_div_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            r_neg_q <= signed_div_i && a_i[WIDTH-1];
            early_q <= early_d;
            cnt_q   <= '0;
          end
        end
        ZERO: begin
          if (!annul_i) begin
            result_q <= early_q ? {early_rem, {WIDTH{1'b0}}} : '0;
            ready_q  <= 1'b1;
          end
        end
        CALC: begin
          if (!annul_i) begin
            rq_q  <= rq_step;
            cnt_q <= cnt_q + 1'b1;
            if (last_iter) begin
              result_q <= {r_fix, q_fix};
              ready_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (annul_i || !start_i) ready_q <= 1'b0;
        end
        default: ready_q <= 1'b0;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_seq_div_unit.sv
// Self-checking bench for seq_div_unit: vector table, random ops vs. a reference model, handshake corners.
module tb_seq_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        signed_div_i;
  logic [31:0] a_i, b_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [63:0] last_res;

  typedef struct {
    bit          sg;
    logic [31:0] a, b, q, r;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    int unsigned lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];

  seq_div_unit #(.WIDTH(32)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .signed_div_i (signed_div_i),
    .a_i          (a_i),
    .b_i          (b_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int unsigned exp_lat(input bit sg, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] am, bm;
    am = (sg && a[31]) ? -a : a;
    bm = (sg && b[31]) ? -b : b;
    if (b != 0 && am < bm) return 2;
`endif
    if (b == 0) return 2;
    return 33;
  endfunction

  // Reference: 64-bit host arithmetic (truncating division), low 32 bits kept.
  task automatic model(input bit sg, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    longint sa, sbv, lq, lr;
    if (b == 0) begin
      q = '0; r = '0;
    end else begin
      if (sg) begin
        sa = longint'($signed(a)); sbv = longint'($signed(b));
      end else begin
        sa = longint'({32'h0, a}); sbv = longint'({32'h0, b});
      end
      lq = sa / sbv;
      lr = sa % sbv;
      q = lq[31:0];
      r = lr[31:0];
    end
  endtask

  task automatic run_op(input bit sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r);
    exp_t e;
    int unsigned n;
    bit got;
    @(negedge clk_i);
    signed_div_i = sg; a_i = a; b_i = b; start_i = 1'b1;
    sb.push_back('{res: {r, q}, lat: exp_lat(sg, a, b)});
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_i); #1;
      n++;
      if (n == 1) begin
        a_i = $urandom; b_i = $urandom; signed_div_i = ~sg;
      end
      if (ready_o) begin
        got = 1'b1;
        break;
      end
    end
    e = sb.pop_front();
    last_res = e.res;
    if (!got) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got no ready in 100 cycles expected ready at cycle %0d", e.lat);
    end else begin
      chk("latency", 64'(n), 64'(e.lat));
      chk("result", result_o, e.res);
      @(posedge clk_i); #1;
      chk("hold_ready", 64'(ready_o), 64'd1);
      chk("hold_result", result_o, e.res);
    end
    @(negedge clk_i);
    start_i = 1'b0;
    @(posedge clk_i); #1;
    chk("drop_ready", 64'(ready_o), 64'd0);
    chk("drop_result", result_o, e.res);
  endtask

  initial begin
    logic [31:0] ra, rb, mq, mr;
    bit rs;
    bit seen;

    vecs[0] = '{0, 32'd100,        32'd7,        32'h0000000E, 32'h00000002};
    vecs[1] = '{1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2] = '{1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001};
    vecs[3] = '{1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'h00000000};
    vecs[4] = '{0, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{0, 32'd5,          32'd0,        32'h00000000, 32'h00000000};
    vecs[6] = '{1, 32'd3,          32'd10,       32'h00000000, 32'h00000003};
    vecs[7] = '{1, 32'hFFFFFFFD,   32'd10,       32'h00000000, 32'hFFFFFFFD};
    vecs[8] = '{0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'h00000000};
    vecs[9] = '{1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'h0000000E, 32'hFFFFFFFE};

    rst_ni = 1'b0; start_i = 1'b0; annul_i = 1'b0;
    signed_div_i = 1'b0; a_i = '0; b_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    last_res = '0;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);

    for (int i = 0; i < 8; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = (i == 3) ? 32'($urandom_range(1, 50)) : $urandom >> $urandom_range(0, 31);
      model(rs, ra, rb, mq, mr);
      run_op(rs, ra, rb, mq, mr);
    end

    // Annul at iteration 10 aborts without touching result_o.
    @(negedge clk_i);
    signed_div_i = 1'b0; a_i = 32'd1000; b_i = 32'd7; start_i = 1'b1;
    @(posedge clk_i);
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    annul_i = 1'b1;
    @(posedge clk_i); #1;
    chk("annul_ready", 64'(ready_o), 64'd0);
    chk("annul_result", result_o, last_res);
    @(negedge clk_i);
    annul_i = 1'b0; start_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (ready_o) seen = 1'b1;
    end
    chk("annul_no_ready", 64'(seen), 64'd0);
    chk("annul_hold_result", result_o, last_res);
    run_op(0, 32'd9, 32'd3, 32'd3, 32'd0);

    // Annul held with start in IDLE blocks acceptance.
    @(negedge clk_i);
    signed_div_i = 1'b0; a_i = 32'd5; b_i = 32'd0; start_i = 1'b1; annul_i = 1'b1;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0; annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (ready_o) seen = 1'b1;
    end
    chk("idle_annul_no_ready", 64'(seen), 64'd0);
    chk("idle_annul_result", result_o, last_res);

    // Annul in DONE with start still high drops ready.
    @(negedge clk_i);
    signed_div_i = 1'b0; a_i = 32'd20; b_i = 32'd4; start_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_i); #1;
      if (ready_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_annul_reached", 64'(seen), 64'd1);
    chk("done_annul_value", result_o, {32'd0, 32'd5});
    last_res = {32'd0, 32'd5};
    @(negedge clk_i);
    annul_i = 1'b1;
    @(posedge clk_i); #1;
    chk("done_annul_ready", 64'(ready_o), 64'd0);
    chk("done_annul_result", result_o, last_res);
    @(negedge clk_i);
    annul_i = 1'b0; start_i = 1'b0;

    // Reset at iteration 20 clears everything.
    @(negedge clk_i);
    signed_div_i = 1'b1; a_i = 32'd12345; b_i = 32'd17; start_i = 1'b1;
    @(posedge clk_i);
    repeat (20) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    chk("midreset_ready", 64'(ready_o), 64'd0);
    chk("midreset_result", result_o, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1; start_i = 1'b0;
    last_res = '0;
    run_op(1, 32'd12345, 32'hFFFFFFEF, 32'hFFFFFD2A, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
